// File: rtl/dds_pkg.sv
// Shared types and helpers for the multi-voice DDS: frame FSM states,
// sine quadrant codes and elaboration-time arithmetic.
package dds_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [1:0] QUAD_0 = 2'd0;
    localparam logic [1:0] QUAD_1 = 2'd1;
    localparam logic [1:0] QUAD_2 = 2'd2;
    localparam logic [1:0] QUAD_3 = 2'd3;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Offset-binary midpoint for a sample of width w.
    function automatic int mid(input int w);
        return 1 << (w - 1);
    endfunction

endpackage

// File: rtl/dds_sine_rom.sv
// Quarter-wave sine magnitude ROM, 2^LUT_AW+1 entries (both endpoints stored),
// synchronous read with one cycle of latency.
module dds_sine_rom #(
    parameter int LUT_AW = 10,
    parameter int OUT_W  = 11
) (
    input  logic              clock,
    input  logic [LUT_AW:0]   addr_i,
    output logic [OUT_W-2:0]  data_o
);
    localparam int  DEPTH   = (1 << LUT_AW) + 1;
    localparam real AMP     = real'((1 << (OUT_W - 1)) - 1);
    localparam real HALF_PI = 1.5707963267948966;

    logic [OUT_W-2:0] rom [DEPTH];

    // Table contents are fixed at elaboration: round(AMP*sin(pi/2*k/2^LUT_AW)).
    for (genvar k = 0; k < DEPTH; k++) begin : g_rom
        localparam int VAL = $rtoi(AMP * $sin(HALF_PI * real'(k) / real'(1 << LUT_AW)) + 0.5);
        assign rom[k] = VAL[OUT_W-2:0];
    end

    always_ff @(posedge clock) begin
        data_o <= rom[addr_i];
    end

endmodule

// File: rtl/dds_poly.sv
// Multi-voice DDS: NUM_CH glided phase accumulators share one sine ROM and one
// multiplier through a 4-stage pipeline; voices are mixed to offset binary and PWM.
module dds_poly
    import dds_pkg::*;
#(
    parameter int  NUM_CH      = 4,
    parameter int  ACC_W       = 32,
    parameter int  LUT_AW      = 10,
    parameter int  OUT_W       = 11,
    parameter int  SCALE_W     = 8,
    parameter int  GLIDE_SHIFT = 8,
    localparam int CH_W        = (NUM_CH > 1) ? clog2(NUM_CH) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               sample_tick,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CH_W-1:0]    cfg_ch,
    input  logic [ACC_W-1:0]   cfg_tuning,
    input  logic [SCALE_W-1:0] cfg_scale,
    output logic [OUT_W-1:0]   sine_out,
    output logic               sample_valid,
    output logic               pwm_out
);
    localparam int LOG_CH = clog2(NUM_CH);
    localparam int IDX_W  = LUT_AW + 2;
    localparam int PW     = OUT_W + SCALE_W;
    localparam int SUM_W  = PW + LOG_CH + 1;
    localparam int MID_V  = mid(OUT_W);
    localparam int MAX_V  = (1 << OUT_W) - 1;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

    state_e state_q, state_d;
    logic [CH_W-1:0] ch_q, ch_d;
    logic            run;

    logic [ACC_W-1:0]   acc_q    [NUM_CH];
    logic [ACC_W-1:0]   cur_tw_q [NUM_CH];
    logic [ACC_W-1:0]   tgt_q    [NUM_CH];
    logic [SCALE_W-1:0] scale_q  [NUM_CH];

    logic signed [ACC_W-1:0] diff, step;
    logic [ACC_W-1:0]        cur_tw_d, acc_d;
    logic                    cfg_take;

    logic             p0_v_q, p0_last_q;
    logic [CH_W-1:0]  p0_ch_q;
    logic [IDX_W-1:0] p0_idx_q;
    logic             p1_v_q, p1_last_q, p1_neg_q, neg_d;
    logic [CH_W-1:0]  p1_ch_q;
    logic [LUT_AW:0]  rom_addr;
    logic [OUT_W-2:0] rom_data;
    logic                    p2_v_q, p2_last_q;
    logic signed [PW-1:0]    p2_q, prod_s;
    logic [PW-1:0]           prod_u;
    logic signed [SUM_W-1:0] sum_q, sum_new, mix;
    logic [OUT_W-1:0]        sat;

    logic [OUT_W-1:0] sine_q, pwm_cnt_q;
    logic             sv_q, pwm_q;

    // Config handshake: a write transfers on a rising edge where cfg_valid and
    // cfg_ready are both high; cfg_ready is high exactly while no frame is in flight.
    assign cfg_ready    = (state_q == ST_IDLE);
    assign cfg_take     = cfg_valid && cfg_ready && ({1'b0, cfg_ch} < (CH_W + 1)'(NUM_CH));
    assign sine_out     = sine_q;
    assign sample_valid = sv_q;
    assign pwm_out      = pwm_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ch_q    <= '0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ch_d    = ch_q;
        run     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (sample_tick) begin
                    state_d = ST_RUN;
                    ch_d    = '0;
                end
            end
            ST_RUN: begin
                run  = 1'b1;
                ch_d = ch_q + 1'b1;
                if (ch_q == LAST_CH) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (p2_v_q && p2_last_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Glide never stalls short of the target: a step that shifts to zero becomes +/-1.
    always_comb begin
        diff = tgt_q[ch_q] - cur_tw_q[ch_q];
        step = diff >>> GLIDE_SHIFT;
        if (step == '0 && diff != '0) step = diff[ACC_W-1] ? '1 : ACC_W'(1);
        cur_tw_d = cur_tw_q[ch_q] + step;
        acc_d    = acc_q[ch_q] + cur_tw_d;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i]    <= '0;
                cur_tw_q[i] <= '0;
                tgt_q[i]    <= '0;
                scale_q[i]  <= '0;
            end
        end else begin
            if (run) begin
                acc_q[ch_q]    <= acc_d;
                cur_tw_q[ch_q] <= cur_tw_d;
            end
            if (cfg_take) begin
                tgt_q[cfg_ch]   <= cfg_tuning;
                scale_q[cfg_ch] <= cfg_scale;
            end
        end
    end

    always_comb begin
        rom_addr = {1'b0, p0_idx_q[LUT_AW-1:0]};
        neg_d    = 1'b0;
        case (p0_idx_q[IDX_W-1 -: 2])
            QUAD_0: begin rom_addr = {1'b0, p0_idx_q[LUT_AW-1:0]}; neg_d = 1'b0; end
            QUAD_1: begin rom_addr = (LUT_AW + 1)'(1 << LUT_AW) - {1'b0, p0_idx_q[LUT_AW-1:0]}; neg_d = 1'b0; end
            QUAD_2: begin rom_addr = {1'b0, p0_idx_q[LUT_AW-1:0]}; neg_d = 1'b1; end
            QUAD_3: begin rom_addr = (LUT_AW + 1)'(1 << LUT_AW) - {1'b0, p0_idx_q[LUT_AW-1:0]}; neg_d = 1'b1; end
            default: ;
        endcase
    end

    dds_sine_rom #(
        .LUT_AW (LUT_AW),
        .OUT_W  (OUT_W)
    ) u_rom (
        .clock  (clock),
        .addr_i (rom_addr),
        .data_o (rom_data)
    );

    always_comb begin
        prod_u  = PW'(rom_data) * PW'(scale_q[p1_ch_q]);
        prod_s  = p1_neg_q ? -$signed(prod_u) : $signed(prod_u);
        sum_new = sum_q + SUM_W'(p2_q);
        mix     = (sum_new >>> LOG_CH) + SUM_W'(MID_V);
        if (mix[SUM_W-1])              sat = '0;
        else if (mix > SUM_W'(MAX_V))  sat = '1;
        else                           sat = mix[OUT_W-1:0];
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            p0_v_q <= 1'b0; p0_last_q <= 1'b0; p0_ch_q <= '0; p0_idx_q <= '0;
            p1_v_q <= 1'b0; p1_last_q <= 1'b0; p1_ch_q <= '0; p1_neg_q <= 1'b0;
            p2_v_q <= 1'b0; p2_last_q <= 1'b0; p2_q <= '0;
            sum_q  <= '0;
            sine_q <= OUT_W'(MID_V);
            sv_q   <= 1'b0;
        end else begin
            p0_v_q    <= run;
            p0_last_q <= run && (ch_q == LAST_CH);
            p0_ch_q   <= ch_q;
            p0_idx_q  <= acc_d[ACC_W-1 -: IDX_W];
            p1_v_q    <= p0_v_q;
            p1_last_q <= p0_last_q;
            p1_ch_q   <= p0_ch_q;
            p1_neg_q  <= neg_d;
            p2_v_q    <= p1_v_q;
            p2_last_q <= p1_last_q;
            p2_q      <= prod_s >>> SCALE_W;
            sv_q      <= 1'b0;
            if (p2_v_q) begin
                if (p2_last_q) begin
                    sum_q  <= '0;
                    sine_q <= sat;
                    sv_q   <= 1'b1;
                end else begin
                    sum_q <= sum_new;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pwm_cnt_q <= '0;
            pwm_q     <= 1'b0;
        end else begin
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            pwm_q     <= (pwm_cnt_q < sine_q);
        end
    end

endmodule

// File: tb/tb_dds_poly.sv
// Bench for dds_poly: two instances (instant retune and glide shift 4) share
// stimulus and are scored against a full-circle floating-point voice model.
module tb_dds_poly;
  localparam int  NUM_CH = 4;
  localparam real PI     = 3.14159265358979323846;

  logic        clock, reset, sample_tick, cfg_valid;
  logic [1:0]  cfg_ch;
  logic [31:0] cfg_tuning;
  logic [7:0]  cfg_scale;
  logic        rdy0, sv0, pwm0, rdy4, sv4, pwm4;
  logic [10:0] sine0, sine4;

  int checks = 0;
  int errors = 0;

  bit [31:0]   m_acc [2][NUM_CH];
  bit [31:0]   m_cur [2][NUM_CH];
  bit [31:0]   m_tgt [NUM_CH];
  int          m_sc  [NUM_CH];
  int          m_out [2];
  logic [10:0] exp_q [$];

  typedef struct {
    bit          wr;
    int          ch;
    logic [31:0] tw;
    int          sc;
    int          exp0;
  } vec_t;
  vec_t tbl [7];

  dds_poly #(.NUM_CH(NUM_CH), .GLIDE_SHIFT(0)) u_dut0 (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .cfg_valid(cfg_valid),
    .cfg_ready(rdy0), .cfg_ch(cfg_ch), .cfg_tuning(cfg_tuning), .cfg_scale(cfg_scale),
    .sine_out(sine0), .sample_valid(sv0), .pwm_out(pwm0));

  dds_poly #(.NUM_CH(NUM_CH), .GLIDE_SHIFT(4)) u_dut4 (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .cfg_valid(cfg_valid),
    .cfg_ready(rdy4), .cfg_ch(cfg_ch), .cfg_tuning(cfg_tuning), .cfg_scale(cfg_scale),
    .sine_out(sine4), .sample_valid(sv4), .pwm_out(pwm4));

  // clock / reset
  initial clock = 1'b1;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, act, exp);
    end
  endtask

  function automatic longint fdiv(input longint a, input longint b);
    longint q;
    q = a / b;
    if ((a % b) != 0 && a < 0) q = q - 1;
    return q;
  endfunction

  function automatic void model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_acc[u][c] = 0;
        m_cur[u][c] = 0;
      end
      m_out[u] = 1024;
    end
    for (int c = 0; c < NUM_CH; c++) begin
      m_tgt[c] = 0;
      m_sc[c]  = 0;
    end
    exp_q.delete();
  endfunction

  function automatic void model_write(input int ch, input logic [31:0] tw, input int sc);
    if (ch < NUM_CH) begin
      m_tgt[ch] = tw;
      m_sc[ch]  = sc;
    end
  endfunction

  // One frame of one instance: glide, advance phase, sample a full-circle sine.
  function automatic void model_frame(input int u);
    logic signed [31:0] d;
    longint step, sum, s, o;
    int idx, mag, shift;
    real v;
    shift = (u == 0) ? 0 : 4;
    sum = 0;
    for (int c = 0; c < NUM_CH; c++) begin
      d = m_tgt[c] - m_cur[u][c];
      step = fdiv(longint'(d), longint'(1) << shift);
      if (step == 0 && d != 0) step = (d < 0) ? -1 : 1;
      m_cur[u][c] = m_cur[u][c] + 32'(step);
      m_acc[u][c] = m_acc[u][c] + m_cur[u][c];
      idx = int'(m_acc[u][c] >> 20);
      v = 1023.0 * $sin(2.0 * PI * real'(idx) / 4096.0);
      mag = $rtoi(((v < 0.0) ? -v : v) + 0.5);
      s = (idx >= 2048) ? -longint'(mag) : longint'(mag);
      sum += fdiv(s * m_sc[c], 256);
    end
    o = fdiv(sum, NUM_CH) + 1024;
    if (o < 0) o = 0;
    if (o > 2047) o = 2047;
    m_out[u] = int'(o);
    exp_q.push_back(11'(o));
  endfunction

  function automatic void model_frame_all();
    model_frame(0);
    model_frame(1);
  endfunction

  // scoreboard
  task automatic sb_check();
    logic [10:0] e0, e4;
    if (exp_q.size() < 2) begin
      checks++;
      errors++;
      $display("FAIL sb_empty: got %0d entries want 2", exp_q.size());
    end else begin
      e0 = exp_q.pop_front();
      e4 = exp_q.pop_front();
      chk("sine_gs0", sine0, e0);
      chk("sine_gs4", sine4, e4);
      chk("valid_align", sv4, 1);
    end
  endtask

  // drivers
  task automatic cfg_write(input int ch, input logic [31:0] tw, input int sc);
    @(negedge clock);
    cfg_valid = 1; cfg_ch = ch[1:0]; cfg_tuning = tw; cfg_scale = sc[7:0];
    @(posedge clock); #1;
    cfg_valid = 0;
    model_write(ch, tw, sc);
  endtask

  task automatic frame(input bit wr, input int ch, input logic [31:0] tw, input int sc);
    int lat;
    @(negedge clock);
    sample_tick = 1; cfg_valid = wr; cfg_ch = ch[1:0]; cfg_tuning = tw; cfg_scale = sc[7:0];
    @(posedge clock); #1;
    sample_tick = 0; cfg_valid = 0;
    if (wr) model_write(ch, tw, sc);
    model_frame_all();
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (sv0) begin lat = i; break; end
    end
    chk("frame_latency", lat, NUM_CH + 3);
    if (lat != 0) sb_check();
    else exp_q.delete();
    @(posedge clock); #1;
    chk("valid_pulse_width", sv0, 0);
  endtask

  initial begin
    int lows, pulses, hi0, hi4, n;
    bit mono;
    logic [31:0] prev, cur;
    logic [31:0] tw;

    reset = 0; sample_tick = 0; cfg_valid = 0; cfg_ch = 0; cfg_tuning = 0; cfg_scale = 0;
    model_reset();
    tbl[0] = '{1, 0, 32'h4000_0000, 255, 1278};
    tbl[1] = '{0, 0, 32'h0,         0,   1024};
    tbl[2] = '{0, 0, 32'h0,         0,   769};
    tbl[3] = '{0, 0, 32'h0,         0,   1024};
    tbl[4] = '{1, 0, 32'h2000_0000, 255, 1204};
    tbl[5] = '{1, 0, 32'h2000_0000, 128, 1151};
    tbl[6] = '{1, 1, 32'h4000_0000, 255, 1369};

    // reset window 5..25 ns with a tick pulsed inside it
    #5 reset = 1;
    #7 sample_tick = 1;
    #10 sample_tick = 0;
    #3 reset = 0;
    #2;
    chk("rst_sine0", sine0, 1024);
    chk("rst_sine4", sine4, 1024);
    chk("rst_pwm", pwm0, 0);
    chk("rst_valid", sv0, 0);
    chk("rst_ready", rdy0, 1);
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      if (sv0 || sv4) pulses++;
    end
    chk("tick_in_reset_ignored", pulses, 0);

    // quarter-turn sequence and mixed voices
    for (int i = 0; i < 7; i++) begin
      frame(tbl[i].wr, tbl[i].ch, tbl[i].tw, tbl[i].sc);
      chk("tbl_sine0", sine0, tbl[i].exp0);
    end

    // config held valid across a frame, extra tick mid-frame
    @(negedge clock); sample_tick = 1;
    @(posedge clock); #1;
    sample_tick = 0;
    model_frame_all();
    lows = rdy0 ? 0 : 1;
    cfg_valid = 1; cfg_ch = 2; cfg_tuning = 32'h0800_0000; cfg_scale = 200;
    pulses = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clock); #1;
      if (sv0) begin pulses++; sb_check(); end
      if (i == 2) sample_tick = 1;
      if (i == 3) sample_tick = 0;
      if (rdy0) break;
      lows++;
    end
    chk("ready_low_cycles", lows, NUM_CH + 3);
    chk("tgt_before_accept", u_dut0.tgt_q[2], m_tgt[2]);
    @(posedge clock); #1;
    cfg_valid = 0;
    model_write(2, 32'h0800_0000, 200);
    chk("tgt_after_accept", u_dut0.tgt_q[2], 32'h0800_0000);
    for (int i = 0; i < 12; i++) begin
      @(posedge clock); #1;
      if (sv0) pulses++;
    end
    chk("dropped_tick_one_pulse", pulses, 1);
    frame(0, 0, 0, 0);

    // PWM duty over one full counter period of held samples
    hi0 = 0; hi4 = 0;
    for (int i = 0; i < 2048; i++) begin
      @(posedge clock); #1;
      if (pwm0) hi0++;
      if (pwm4) hi4++;
    end
    chk("pwm_duty0", hi0, m_out[0]);
    chk("pwm_duty4", hi4, m_out[1]);
    chk("sine_held0", sine0, m_out[0]);

    // reset during RUN cycle 2 aborts the frame
    @(negedge clock); sample_tick = 1;
    @(posedge clock); #1; sample_tick = 0;
    @(posedge clock);
    @(posedge clock); #1;
    reset = 1;
    #1;
    chk("midrst_sine", sine0, 1024);
    chk("midrst_ready", rdy0, 1);
    chk("midrst_valid", sv0, 0);
    model_reset();
    @(negedge clock); @(negedge clock); reset = 0;
    pulses = 0;
    for (int i = 0; i < 14; i++) begin
      @(posedge clock); #1;
      if (sv0 || sv4) pulses++;
    end
    chk("midrst_no_valid", pulses, 0);
    chk("midrst_acc_cleared", u_dut0.acc_q[0], 0);

    // glide up to 0x1000_0000 on the shift-4 instance
    cfg_write(0, 32'h1000_0000, 200);
    frame(0, 0, 0, 0);
    chk("glide_first_step", u_dut4.cur_tw_q[0], 32'h0100_0000);
    mono = 1; prev = u_dut4.cur_tw_q[0]; n = 0;
    while (u_dut4.cur_tw_q[0] != 32'h1000_0000 && n < 600) begin
      frame(0, 0, 0, 0);
      cur = u_dut4.cur_tw_q[0];
      if (cur < prev) mono = 0;
      prev = cur;
      n++;
    end
    chk("glide_up_mono", mono, 1);
    chk("glide_up_land", u_dut4.cur_tw_q[0], 32'h1000_0000);
    frame(0, 0, 0, 0);
    chk("glide_up_hold", u_dut4.cur_tw_q[0], 32'h1000_0000);

    // glide back down to 0
    cfg_write(0, 32'h0, 200);
    mono = 1; prev = u_dut4.cur_tw_q[0]; n = 0;
    while (u_dut4.cur_tw_q[0] != 32'h0 && n < 600) begin
      frame(0, 0, 0, 0);
      cur = u_dut4.cur_tw_q[0];
      if (cur > prev) mono = 0;
      prev = cur;
      n++;
    end
    chk("glide_down_mono", mono, 1);
    chk("glide_down_land", u_dut4.cur_tw_q[0], 32'h0);
    chk("glide_model", u_dut4.cur_tw_q[0], m_cur[1][0]);

    // randomized configuration and frames
    for (int it = 0; it < 20; it++) begin
      n = $urandom_range(0, 2);
      for (int w = 0; w < n; w++) begin
        tw = $urandom();
        cfg_write($urandom_range(0, NUM_CH - 1), tw >> $urandom_range(0, 8), $urandom_range(0, 255));
      end
      tw = $urandom();
      frame($urandom_range(0, 1), $urandom_range(0, NUM_CH - 1), tw >> $urandom_range(2, 10),
            $urandom_range(0, 255));
      for (int f = 0; f < int'($urandom_range(0, 3)); f++) frame(0, 0, 0, 0);
    end

    chk("sb_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
